// File: rtl/keypad_scan_controller_pkg.sv
// keypad_scan_controller_pkg: shared FSM encoding, default geometry and width helper.
package keypad_scan_controller_pkg;

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, EVAL = 2'd2} state_e;

   localparam int ROWS_DEF = 4;
   localparam int COLS_DEF = 4;

   function automatic int code_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/keypad_scan_controller_tick.sv
// scan_tick_gen: free-running prescaler, one-clk tick on wrap, held at zero while disabled.
module scan_tick_gen #(
   parameter int TICK_BITS = 12
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic tick
);

   logic [TICK_BITS-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= enable ? cnt_q + TICK_BITS'(1) : '0;

   assign tick = enable && (&cnt_q);

endmodule

// File: rtl/keypad_scan_controller.sv
// keypad_scan_controller: row-sweeping keypad scanner with sweep debounce and valid/ack event port.
module keypad_scan_controller
   import keypad_scan_controller_pkg::*;
#(
   parameter  int ROWS      = ROWS_DEF,
   parameter  int COLS      = COLS_DEF,
   parameter  int TICK_BITS = 12,
   parameter  int DEBOUNCE  = 4,
   localparam int KW        = code_width(ROWS*COLS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            enable,
   input  logic [COLS-1:0] col_n,
   output logic [ROWS-1:0] row_n,
   output logic [KW-1:0]   key_code,
   output logic            key_valid,
   input  logic            key_ack,
   output logic            key_overrun
);

   localparam int N  = ROWS*COLS;
   localparam int RW = code_width(ROWS);

   state_e          state_q, state_d;
   logic [COLS-1:0] col_s1_q, col_s2_q, col;
   logic [RW-1:0]   r_q, r_d;
   logic [N-1:0]    acc_q, acc_d;
   logic [KW-1:0]   cand_q, cand_d, code_q, code_d, hit_code;
   logic [3:0]      cnt_q, cnt_d;
   logic            rep_q, rep_d, valid_q, valid_d, ovr_q, ovr_d;
   logic [1:0]      hits;
   logic            tick, fire, last_row;

   assign col      = ~col_s2_q;
   assign last_row = r_q == RW'(ROWS-1);

   scan_tick_gen #(.TICK_BITS(TICK_BITS)) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable && state_q == SCAN),
      .tick   (tick)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;

   always_comb
      state_d = !enable          ? IDLE :
                state_q == IDLE  ? SCAN :
                state_q == SCAN  ? ((tick && last_row) ? EVAL : SCAN) : SCAN;

   always_comb
      row_n = (state_q == SCAN) ? ~(ROWS'(1) << r_q) : '1;

   // hits saturates at 2: only none / one / many matters for classification
   always_comb begin
      hits     = 2'd0;
      hit_code = '0;
      for (int i = 0; i < N; i++)
         if (acc_q[i]) begin
            if (hits != 2'd2) hits = hits + 2'd1;
            hit_code = KW'(i);
         end
   end

   always_comb begin
      r_d    = r_q;
      acc_d  = acc_q;
      cand_d = cand_q;
      cnt_d  = cnt_q;
      rep_d  = rep_q;
      fire   = 1'b0;
      if (!enable) begin
         r_d   = '0;
         acc_d = '0;
         cnt_d = '0;
         rep_d = 1'b0;
      end else if (state_q == SCAN && tick) begin
         acc_d = acc_q | (N'(col) << (int'(r_q) * COLS));
         r_d   = last_row ? '0 : r_q + RW'(1);
      end else if (state_q == EVAL) begin
         acc_d  = '0;
         r_d    = '0;
         cnt_d  = (hits != 2'd1)      ? 4'd0 :
                  (hit_code != cand_q) ? 4'd1 :
                  (cnt_q == 4'(DEBOUNCE)) ? cnt_q : cnt_q + 4'd1;
         cand_d = (hits == 2'd1) ? hit_code : cand_q;
         fire   = hits == 2'd1 && cnt_d == 4'(DEBOUNCE) && !rep_q;
         rep_d  = (hits == 2'd0) ? 1'b0 : (rep_q || fire);
      end
      valid_d = fire || (valid_q && !key_ack);
      code_d  = (fire && (!valid_q || key_ack)) ? hit_code : code_q;
      ovr_d   = (valid_q && key_ack) ? 1'b0 : (ovr_q || (fire && valid_q));
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         col_s1_q <= '1;
         col_s2_q <= '1;
         r_q      <= '0;
         acc_q    <= '0;
         cand_q   <= '0;
         cnt_q    <= '0;
         rep_q    <= 1'b0;
         valid_q  <= 1'b0;
         code_q   <= '0;
         ovr_q    <= 1'b0;
      end else begin
         col_s1_q <= col_n;
         col_s2_q <= col_s1_q;
         r_q      <= r_d;
         acc_q    <= acc_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         rep_q    <= rep_d;
         valid_q  <= valid_d;
         code_q   <= code_d;
         ovr_q    <= ovr_d;
      end

   assign key_valid   = valid_q;
   assign key_code    = code_q;
   assign key_overrun = ovr_q;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// tb_keypad_scan_controller: directed bench with a behavioural 4x4 key matrix on the row/column pins.
module tb_keypad_scan_controller;

   logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, key_ack = 1'b0;
   logic [3:0]  col_n, row_n, key_code;
   logic        key_valid, key_overrun;
   logic [15:0] keys = '0;
   logic [3:0]  exp_row;
   int          tests = 0, failed = 0;

   always #5 clk = ~clk;

   // pressed switch shorts its column to a row that is driven low
   always_comb begin
      col_n = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && row_n[r] === 1'b0) col_n[c] = 1'b0;
   end

   keypad_scan_controller #(.ROWS(4), .COLS(4), .TICK_BITS(2), .DEBOUNCE(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .col_n       (col_n),
      .row_n       (row_n),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_ack     (key_ack),
      .key_overrun (key_overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_eval;
      int n = 0;
      @(negedge clk);
      while (row_n !== 4'hF && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("eval_reached", 32'(row_n), 32'hF);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_row_n", 32'(row_n), 32'hF);
      chk("rst_valid", 32'(key_valid), 32'h0);
      chk("rst_code", 32'(key_code), 32'h0);
      chk("rst_overrun", 32'(key_overrun), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      enable = 1'b1;
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_row = ~(4'b0001 << i);
            chk("row_step", 32'(row_n), 32'(exp_row));
            chk("valid_idle", 32'(key_valid), 32'h0);
         end
      @(negedge clk);
      chk("eval_rows_high", 32'(row_n), 32'hF);

      keys = 16'h0200;
      wait_eval;
      wait_eval;
      wait_eval;
      chk("k9_not_yet", 32'(key_valid), 32'h0);
      @(negedge clk);
      chk("k9_valid", 32'(key_valid), 32'h1);
      chk("k9_code", 32'(key_code), 32'h9);
      wait_eval;
      wait_eval;
      chk("k9_held_valid", 32'(key_valid), 32'h1);
      chk("k9_held_code", 32'(key_code), 32'h9);
      chk("k9_single_event", 32'(key_overrun), 32'h0);
      @(negedge clk);
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
      chk("k9_acked", 32'(key_valid), 32'h0);
      wait_eval;
      @(negedge clk);
      chk("k9_no_repeat", 32'(key_valid), 32'h0);
      keys = '0;
      wait_eval;

      for (int i = 0; i < 8; i++) begin
         keys = (i % 2 == 0) ? 16'h0001 : 16'h0000;
         wait_eval;
         chk("bounce_quiet", 32'(key_valid), 32'h0);
      end
      @(negedge clk);
      chk("bounce_final", 32'(key_valid), 32'h0);

      keys = 16'h0081;
      for (int i = 0; i < 6; i++) begin
         wait_eval;
         chk("ghost_quiet", 32'(key_valid), 32'h0);
      end
      @(negedge clk);
      chk("ghost_final", 32'(key_valid), 32'h0);
      keys = '0;
      wait_eval;

      keys = 16'h0200;
      wait_eval;
      wait_eval;
      wait_eval;
      @(negedge clk);
      chk("ovr_first_valid", 32'(key_valid), 32'h1);
      chk("ovr_first_code", 32'(key_code), 32'h9);
      keys = '0;
      wait_eval;
      keys = 16'h0010;
      wait_eval;
      wait_eval;
      wait_eval;
      @(negedge clk);
      chk("ovr_set", 32'(key_overrun), 32'h1);
      chk("ovr_code_kept", 32'(key_code), 32'h9);
      chk("ovr_valid_kept", 32'(key_valid), 32'h1);
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
      chk("ovr_ack_valid", 32'(key_valid), 32'h0);
      chk("ovr_ack_clear", 32'(key_overrun), 32'h0);
      keys = '0;
      wait_eval;
      wait_eval;

      keys = 16'h0200;
      wait_eval;
      wait_eval;
      wait_eval;
      @(negedge clk);
      chk("en_valid", 32'(key_valid), 32'h1);
      repeat (2) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("en_drop_rows", 32'(row_n), 32'hF);
      chk("en_drop_valid", 32'(key_valid), 32'h1);
      chk("en_drop_code", 32'(key_code), 32'h9);
      keys = '0;
      enable = 1'b1;
      repeat (6) @(negedge clk);
      chk("en_resume_row1", 32'(row_n), 32'hD);
      rst_n = 1'b0;
      #1;
      chk("async_rst_rows", 32'(row_n), 32'hF);
      chk("async_rst_valid", 32'(key_valid), 32'h0);
      chk("async_rst_code", 32'(key_code), 32'h0);
      chk("async_rst_overrun", 32'(key_overrun), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
